// File: rtl/route_compute_unit_if.sv
// Head-flit / route handshake between the input VC buffers, the route stage and the switch allocator.
interface route_compute_unit_if #(
  parameter int unsigned VC            = 4,
  parameter int unsigned PhitPerFlit   = 2,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned REQUEST_WIDTH = 3,
  parameter int unsigned COUNT_WIDTH   = 16
);
   logic [VC*PhitPerFlit*DATA_WIDTH-1:0] HeadFlit;
   logic [VC-1:0]                        head_valid;
   logic [VC-1:0]                        head_ready;
   logic [VC-1:0]                        tail_sent;
   logic [VC*REQUEST_WIDTH-1:0]          RequestMessage;
   logic [VC-1:0]                        route_valid;
   logic [VC-1:0]                        dest_error;
   logic [COUNT_WIDTH-1:0]               pkt_count;

   modport master (
      output HeadFlit, head_valid, tail_sent,
      input  head_ready, RequestMessage, route_valid, dest_error, pkt_count
   );

   modport slave (
      input  HeadFlit, head_valid, tail_sent,
      output head_ready, RequestMessage, route_valid, dest_error, pkt_count
   );
endinterface

// File: rtl/route_compute_unit.sv
// Per-VC registered route computation: latches XY/YX output port on head acceptance, holds it until tail.
module route_compute_unit #(
  parameter int unsigned DIM_X         = 2,
  parameter int unsigned DIM_Y         = 2,
  parameter int unsigned INDEX         = 1,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned PhitPerFlit   = 2,
  parameter int unsigned VC            = 4,
  parameter int unsigned REQUEST_WIDTH = 3,
  parameter int unsigned COORD_WIDTH   = 4,
  parameter int unsigned ROUTING       = 0,
  parameter int unsigned COUNT_WIDTH   = 16
) (
   input logic                clk,
   input logic                rst,
   route_compute_unit_if.slave rcu
);
   localparam int unsigned FlitWidth = PhitPerFlit * DATA_WIDTH;
   localparam int unsigned NodeX     = INDEX % DIM_X;
   localparam int unsigned NodeY     = INDEX / DIM_X;

   localparam logic [REQUEST_WIDTH-1:0] PortLocal = '0;
   localparam logic [REQUEST_WIDTH-1:0] PortEast  = REQUEST_WIDTH'(1);
   localparam logic [REQUEST_WIDTH-1:0] PortNorth = REQUEST_WIDTH'(2);
   localparam logic [REQUEST_WIDTH-1:0] PortWest  = REQUEST_WIDTH'(3);
   localparam logic [REQUEST_WIDTH-1:0] PortSouth = REQUEST_WIDTH'(4);

   typedef enum logic {Idle = 1'b0, Routed = 1'b1} vcState_e;

   vcState_e                 state     [VC];
   vcState_e                 nextState [VC];
   logic [REQUEST_WIDTH-1:0] routeReg  [VC];
   logic [REQUEST_WIDTH-1:0] newRoute  [VC];
   logic [VC-1:0]            errReg;
   logic [VC-1:0]            newErr;
   logic [VC-1:0]            accept;
   logic [COUNT_WIDTH-1:0]   pktCount;
   logic [COUNT_WIDTH-1:0]   acceptCount;
   logic                     unusedFlitBits;

   assign unusedFlitBits = ^rcu.HeadFlit;

   function automatic logic [REQUEST_WIDTH-1:0] computeRoute(
      input logic [COORD_WIDTH-1:0] destX,
      input logic [COORD_WIDTH-1:0] destY
   );
      logic [REQUEST_WIDTH-1:0] xPort;
      logic [REQUEST_WIDTH-1:0] yPort;
      xPort = PortLocal;
      yPort = PortLocal;
      if (32'(destX) > NodeX)      xPort = PortEast;
      else if (32'(destX) < NodeX) xPort = PortWest;
      if (32'(destY) > NodeY)      yPort = PortNorth;
      else if (32'(destY) < NodeY) yPort = PortSouth;
      if (ROUTING == 0) return (xPort != PortLocal) ? xPort : yPort;
      else              return (yPort != PortLocal) ? yPort : xPort;
   endfunction

   always_comb begin
      newErr = '0;
      for (int unsigned v = 0; v < VC; v++) begin
         logic [COORD_WIDTH-1:0] dY;
         logic [COORD_WIDTH-1:0] dX;
         dY = rcu.HeadFlit[v*FlitWidth +: COORD_WIDTH];
         dX = rcu.HeadFlit[v*FlitWidth + COORD_WIDTH +: COORD_WIDTH];
         newErr[v]   = (32'(dX) >= DIM_X) || (32'(dY) >= DIM_Y);
         // Out-of-range destinations route locally so nothing is sent off the mesh.
         newRoute[v] = newErr[v] ? PortLocal : computeRoute(dX, dY);
      end
   end

   always_ff @(posedge clk) begin
      for (int unsigned v = 0; v < VC; v++) begin
         if (rst) state[v] <= Idle;
         else     state[v] <= nextState[v];
      end
   end

   always_comb begin
      accept = '0;
      for (int unsigned v = 0; v < VC; v++) begin
         nextState[v] = state[v];
         case (state[v])
            Idle: begin
               accept[v] = rcu.head_valid[v];
               if (rcu.head_valid[v]) nextState[v] = Routed;
            end
            Routed: if (rcu.tail_sent[v]) nextState[v] = Idle;
            default: nextState[v] = Idle;
         endcase
      end
   end

   always_comb begin
      acceptCount = '0;
      for (int unsigned v = 0; v < VC; v++)
         if (accept[v]) acceptCount = acceptCount + COUNT_WIDTH'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         errReg   <= '0;
         pktCount <= '0;
         for (int unsigned v = 0; v < VC; v++) routeReg[v] <= '0;
      end else begin
         pktCount <= pktCount + acceptCount;
         for (int unsigned v = 0; v < VC; v++) begin
            if (accept[v]) begin
               routeReg[v] <= newRoute[v];
               errReg[v]   <= newErr[v];
            end else if (state[v] == Routed && rcu.tail_sent[v]) begin
               routeReg[v] <= '0;
               errReg[v]   <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      rcu.head_ready     = '0;
      rcu.route_valid    = '0;
      rcu.RequestMessage = '0;
      rcu.dest_error     = errReg;
      rcu.pkt_count      = pktCount;
      for (int unsigned v = 0; v < VC; v++) begin
         rcu.head_ready[v]  = (state[v] == Idle);
         rcu.route_valid[v] = (state[v] == Routed);
         rcu.RequestMessage[v*REQUEST_WIDTH +: REQUEST_WIDTH] = routeReg[v];
      end
   end
endmodule

// File: tb/tb_route_compute_unit.sv
// Bench for route_compute_unit: XY instance and YX instance (2-bit counter) on a 4x4 mesh at node (1,1).
module tb_route_compute_unit;
   localparam int VCN = 4;
   localparam int DW  = 8;
   localparam int PPF = 2;
   localparam int RW  = 3;
   localparam int CW  = 4;
   localparam int FW  = DW * PPF;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   route_compute_unit_if #(.VC(VCN), .PhitPerFlit(PPF), .DATA_WIDTH(DW),
                           .REQUEST_WIDTH(RW), .COUNT_WIDTH(16)) ifA ();
   route_compute_unit_if #(.VC(VCN), .PhitPerFlit(PPF), .DATA_WIDTH(DW),
                           .REQUEST_WIDTH(RW), .COUNT_WIDTH(2)) ifB ();

   route_compute_unit #(.DIM_X(4), .DIM_Y(4), .INDEX(5), .DATA_WIDTH(DW), .PhitPerFlit(PPF),
                        .VC(VCN), .REQUEST_WIDTH(RW), .COORD_WIDTH(CW), .ROUTING(0),
                        .COUNT_WIDTH(16)) dutA (.clk(clk), .rst(rst), .rcu(ifA.slave));
   route_compute_unit #(.DIM_X(4), .DIM_Y(4), .INDEX(5), .DATA_WIDTH(DW), .PhitPerFlit(PPF),
                        .VC(VCN), .REQUEST_WIDTH(RW), .COORD_WIDTH(CW), .ROUTING(1),
                        .COUNT_WIDTH(2)) dutB (.clk(clk), .rst(rst), .rcu(ifB.slave));

   typedef struct {
      int inst; int vc; int dx; int dy; int port; bit err;
   } vec_t;

   typedef struct {
      int inst; int vc; int port; bit err;
   } exp_t;

   exp_t sb[$];
   int   nChecks = 0;
   int   nFail   = 0;
   int   expCount[2];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic driveHead(input int inst, input int vc, input int dx, input int dy, input bit valid);
      logic [FW-1:0] f;
      f = FW'($urandom);
      f[0 +: CW]  = CW'(dy);
      f[CW +: CW] = CW'(dx);
      if (inst == 0) begin
         ifA.HeadFlit[vc*FW +: FW] = f;
         ifA.head_valid[vc]        = valid;
      end else begin
         ifB.HeadFlit[vc*FW +: FW] = f;
         ifB.head_valid[vc]        = valid;
      end
   endtask

   task automatic setTail(input int inst, input int vc, input bit val);
      if (inst == 0) ifA.tail_sent[vc] = val;
      else           ifB.tail_sent[vc] = val;
   endtask

   function automatic logic [31:0] routeOf(input int inst, input int vc);
      logic [VCN*RW-1:0] rm;
      rm = (inst == 0) ? ifA.RequestMessage : ifB.RequestMessage;
      return 32'(rm[vc*RW +: RW]);
   endfunction

   function automatic logic [31:0] bitOf(input int inst, input int which, input int vc);
      logic [VCN-1:0] b;
      case (which)
         0:       b = (inst == 0) ? ifA.route_valid : ifB.route_valid;
         1:       b = (inst == 0) ? ifA.dest_error  : ifB.dest_error;
         default: b = (inst == 0) ? ifA.head_ready  : ifB.head_ready;
      endcase
      return 32'(b[vc]);
   endfunction

   function automatic logic [31:0] countOf(input int inst);
      return (inst == 0) ? 32'(ifA.pkt_count) : 32'(ifB.pkt_count);
   endfunction

   task automatic bumpCount(input int inst, input int n);
      if (inst == 0) expCount[0] = (expCount[0] + n) % 65536;
      else           expCount[1] = (expCount[1] + n) % 4;
   endtask

   task automatic checkIdle(input string name, input int inst);
      for (int v = 0; v < VCN; v++) begin
         check({name, " head_ready"},  bitOf(inst, 2, v), 32'd1);
         check({name, " route_valid"}, bitOf(inst, 0, v), 32'd0);
         check({name, " dest_error"},  bitOf(inst, 1, v), 32'd0);
         check({name, " route"},       routeOf(inst, v),  32'd0);
      end
      check({name, " pkt_count"}, countOf(inst), 32'(expCount[inst]));
   endtask

   task automatic sendPacket(input int inst, input int vc, input int dx, input int dy,
                             input int port, input bit err);
      exp_t e;
      @(negedge clk);
      driveHead(inst, vc, dx, dy, 1'b1);
      sb.push_back('{inst, vc, port, err});
      @(negedge clk);
      driveHead(inst, vc, 0, 0, 1'b0);
      bumpCount(inst, 1);
      e = sb.pop_front();
      check("route",       routeOf(e.inst, e.vc),     32'(e.port));
      check("dest_error",  bitOf(e.inst, 1, e.vc),    32'(e.err));
      check("route_valid", bitOf(e.inst, 0, e.vc),    32'd1);
      check("head_ready",  bitOf(e.inst, 2, e.vc),    32'd0);
      check("pkt_count",   countOf(e.inst),           32'(expCount[e.inst]));
      setTail(e.inst, e.vc, 1'b1);
      @(negedge clk);
      setTail(e.inst, e.vc, 1'b0);
      check("tail route_valid", bitOf(e.inst, 0, e.vc), 32'd0);
      check("tail dest_error",  bitOf(e.inst, 1, e.vc), 32'd0);
      check("tail route",       routeOf(e.inst, e.vc),   32'd0);
      check("tail head_ready",  bitOf(e.inst, 2, e.vc), 32'd1);
   endtask

   vec_t vecs[16];

   initial begin
      // inst, vc, destX, destY, port, err   (node is X=1, Y=1)
      vecs[0]  = '{0, 0, 3, 1, 1, 1'b0};
      vecs[1]  = '{0, 1, 1, 0, 4, 1'b0};
      vecs[2]  = '{0, 2, 1, 1, 0, 1'b0};
      vecs[3]  = '{0, 3, 0, 3, 3, 1'b0};
      vecs[4]  = '{0, 0, 2, 3, 1, 1'b0};
      vecs[5]  = '{0, 1, 1, 3, 2, 1'b0};
      vecs[6]  = '{0, 2, 4, 0, 0, 1'b1};
      vecs[7]  = '{0, 3, 1, 5, 0, 1'b1};
      vecs[8]  = '{0, 0, 15, 15, 0, 1'b1};
      vecs[9]  = '{1, 0, 3, 3, 2, 1'b0};
      vecs[10] = '{1, 1, 0, 1, 3, 1'b0};
      vecs[11] = '{1, 2, 3, 1, 1, 1'b0};
      vecs[12] = '{1, 3, 0, 0, 4, 1'b0};
      vecs[13] = '{1, 0, 1, 1, 0, 1'b0};
      vecs[14] = '{1, 1, 2, 0, 4, 1'b0};
      vecs[15] = '{1, 2, 0, 4, 0, 1'b1};

      expCount[0] = 0;
      expCount[1] = 0;
      rst = 1'b1;
      ifA.HeadFlit = '0; ifA.head_valid = '0; ifA.tail_sent = '0;
      ifB.HeadFlit = '0; ifB.head_valid = '0; ifB.tail_sent = '0;
      repeat (2) @(negedge clk);
      checkIdle("reset A", 0);
      checkIdle("reset B", 1);
      rst = 1'b0;

      for (int i = 0; i < 16; i++)
         sendPacket(vecs[i].inst, vecs[i].vc, vecs[i].dx, vecs[i].dy, vecs[i].port, vecs[i].err);

      // Hold and release on A VC0; second head waits while the first packet is routed
      @(negedge clk);
      driveHead(0, 0, 3, 1, 1'b1);
      @(negedge clk);
      bumpCount(0, 1);
      check("hold k route", routeOf(0, 0), 32'd1);
      driveHead(0, 0, 0, 1, 1'b1);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         check("hold route",      routeOf(0, 0),  32'd1);
         check("hold head_ready", bitOf(0, 2, 0), 32'd0);
         check("hold pkt_count",  countOf(0),     32'(expCount[0]));
      end
      setTail(0, 0, 1'b1);
      @(negedge clk);
      setTail(0, 0, 1'b0);
      check("tail-wins route_valid", bitOf(0, 0, 0), 32'd0);
      check("tail-wins head_ready",  bitOf(0, 2, 0), 32'd1);
      check("tail-wins pkt_count",   countOf(0),     32'(expCount[0]));
      @(negedge clk);
      bumpCount(0, 1);
      driveHead(0, 0, 0, 0, 1'b0);
      check("release route",       routeOf(0, 0),  32'd3);
      check("release route_valid", bitOf(0, 0, 0), 32'd1);
      check("release pkt_count",   countOf(0),     32'(expCount[0]));
      setTail(0, 0, 1'b1);
      @(negedge clk);
      setTail(0, 0, 1'b0);

      // All four VCs accept in the same cycle
      driveHead(0, 0, 3, 1, 1'b1);
      driveHead(0, 1, 1, 0, 1'b1);
      driveHead(0, 2, 1, 1, 1'b1);
      driveHead(0, 3, 0, 1, 1'b1);
      @(negedge clk);
      ifA.head_valid = '0;
      bumpCount(0, 4);
      check("all-vc routes",      32'(ifA.RequestMessage), {20'd0, 3'd3, 3'd0, 3'd4, 3'd1});
      check("all-vc route_valid", 32'(ifA.route_valid),    32'hF);
      check("all-vc pkt_count",   countOf(0),              32'(expCount[0]));
      ifA.tail_sent = '1;
      @(negedge clk);
      ifA.tail_sent = '0;
      checkIdle("all-vc tail", 0);

      // Counter wrap on the 2-bit instance
      for (int i = 0; i < 4 && expCount[1] != 3; i++)
         sendPacket(1, 0, 1, 1, 0, 1'b0);
      check("wrap precondition", countOf(1), 32'd3);
      sendPacket(1, 1, 1, 1, 0, 1'b0);
      check("wrap pkt_count", countOf(1), 32'd0);

      // tail_sent while idle is ignored
      ifA.tail_sent = '1;
      @(negedge clk);
      ifA.tail_sent = '0;
      checkIdle("idle tail", 0);

      // Reset aborts a packet in flight and overrides a concurrent head
      driveHead(0, 2, 3, 3, 1'b1);
      @(negedge clk);
      driveHead(0, 2, 0, 0, 1'b0);
      bumpCount(0, 1);
      check("pre-reset route_valid", bitOf(0, 0, 2), 32'd1);
      rst = 1'b1;
      driveHead(0, 0, 3, 1, 1'b1);
      setTail(0, 2, 1'b1);
      @(negedge clk);
      driveHead(0, 0, 0, 0, 1'b0);
      setTail(0, 2, 1'b0);
      expCount[0] = 0;
      expCount[1] = 0;
      checkIdle("mid-packet reset", 0);
      rst = 1'b0;
      @(negedge clk);
      checkIdle("post reset", 0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end
endmodule
